// File: rtl/ibex_pkg.sv
// Shared definitions for the register-file write sequencer slice.
// Provides RF address widths, the write-back source enum and address helpers.
package ibex_pkg;

   localparam int unsigned RF_AW_RV32I = 5;
   localparam int unsigned RF_AW_RV32E = 4;

   typedef enum logic {
      WB_SRC_EX,
      WB_SRC_LSU
   } wb_src_e;

   // RV32E drops address bit 4 from every compare.
   function automatic logic [4:0] rf_addr_mask(
      input logic [4:0] a,
      input bit         rv32e
   );
      return rv32e ? {1'b0, a[RF_AW_RV32E-1:0]} : a;
   endfunction

   function automatic logic rf_addr_eq(
      input logic [4:0] a,
      input logic [4:0] b,
      input bit         rv32e
   );
      return rf_addr_mask(a, rv32e) == rf_addr_mask(b, rv32e);
   endfunction

   function automatic logic rf_addr_nz(
      input logic [4:0] a,
      input bit         rv32e
   );
      return rf_addr_mask(a, rv32e) != 5'd0;
   endfunction

endpackage

// File: rtl/ibex_wb_load_fifo.sv
// In-order scoreboard of pending load destinations with a per-entry valid
// vector so every entry can be compared against operand/EX addresses at once.
// Ports: clk_i, rst_i (sync, high); push_i/pop_i with addr_i; head_o,
// full_o, empty_o; cmp_{a,b,ex}_i -> match_{a,b,ex}_o (x0 never matches).
module ibex_wb_load_fifo
   import ibex_pkg::*;
#(
   parameter bit          RV32E = 1'b0,
   parameter int unsigned Depth = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic [4:0] addr_i,
   output logic [4:0] head_o,
   output logic       full_o,
   output logic       empty_o,
   input  logic [4:0] cmp_a_i,
   input  logic [4:0] cmp_b_i,
   input  logic [4:0] cmp_ex_i,
   output logic       match_a_o,
   output logic       match_b_o,
   output logic       match_ex_o
);

   localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CW = $clog2(Depth + 1);

   logic [4:0]       addr_q [Depth];
   logic [Depth-1:0] valid_q;
   logic [PW-1:0]    wptr_q;
   logic [PW-1:0]    rptr_q;
   logic [CW-1:0]    cnt_q;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
      return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full_o  = (cnt_q == CW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign head_o  = addr_q[rptr_q];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         if (pop_ok) begin
            valid_q[rptr_q] <= 1'b0;
            rptr_q          <= ptr_nxt(rptr_q);
         end
         if (push_ok) begin
            valid_q[wptr_q] <= 1'b1;
            wptr_q          <= ptr_nxt(wptr_q);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Payload needs no reset: valid_q qualifies every use.
   always_ff @(posedge clk_i) begin
      if (push_ok) addr_q[wptr_q] <= addr_i;
   end

   always_comb begin
      match_a_o  = 1'b0;
      match_b_o  = 1'b0;
      match_ex_o = 1'b0;
      for (int i = 0; i < Depth; i++) begin
         if (valid_q[i]) begin
            if (rf_addr_eq(addr_q[i], cmp_a_i, RV32E))  match_a_o  = 1'b1;
            if (rf_addr_eq(addr_q[i], cmp_b_i, RV32E))  match_b_o  = 1'b1;
            if (rf_addr_eq(addr_q[i], cmp_ex_i, RV32E)) match_ex_o = 1'b1;
         end
      end
      match_a_o  = match_a_o && rf_addr_nz(cmp_a_i, RV32E);
      match_b_o  = match_b_o && rf_addr_nz(cmp_b_i, RV32E);
      match_ex_o = match_ex_o && rf_addr_nz(cmp_ex_i, RV32E);
   end

endmodule

// File: rtl/ibex_rf_write_sequencer.sv
// Merges EX results and in-order load responses onto the single RF write
// port, holds EX back on WAW against pending loads, and flags ID hazards.
// Ports: clk_i, rst_i (sync, high); ex_* handshake; lsu_alloc_*/lsu_waddr_i;
// lsu_rvalid_i/rdata/err; raddr_{a,b}_i -> hazard_{a,b}_o; rf_* registered
// write port; proto_err_o sticky. Macro IBEX_RF_WB_FWD_EN adds fwd_* ports.
module ibex_rf_write_sequencer
   import ibex_pkg::*;
#(
   parameter bit          RV32E     = 1'b0,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned LsuDepth  = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 ex_valid_i,
   output logic                 ex_ready_o,
   input  logic [4:0]           ex_waddr_i,
   input  logic [DataWidth-1:0] ex_wdata_i,
   input  logic                 lsu_alloc_i,
   output logic                 lsu_alloc_rdy_o,
   input  logic [4:0]           lsu_waddr_i,
   input  logic                 lsu_rvalid_i,
   input  logic [DataWidth-1:0] lsu_rdata_i,
   input  logic                 lsu_err_i,
   input  logic [4:0]           raddr_a_i,
   input  logic [4:0]           raddr_b_i,
   output logic                 hazard_a_o,
   output logic                 hazard_b_o,
`ifdef IBEX_RF_WB_FWD_EN
   output logic                 fwd_a_o,
   output logic                 fwd_b_o,
   output logic [DataWidth-1:0] fwd_data_o,
`endif
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,
   output logic                 rf_we_o,
   output logic                 proto_err_o
);

   logic                 lsu_full;
   logic                 lsu_empty;
   logic                 lsu_pop;
   logic [4:0]           lsu_head;
   logic                 match_a;
   logic                 match_b;
   logic                 match_ex;
   logic                 ex_fire;
   wb_src_e              wb_src;
   logic                 wb_acc;
   logic                 wb_drop;
   logic [4:0]           wb_addr;
   logic [DataWidth-1:0] wb_data;
   logic                 wb_we;
   logic                 os_a;
   logic                 os_b;

   ibex_wb_load_fifo #(
      .RV32E (RV32E),
      .Depth (LsuDepth)
   ) u_load_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (lsu_alloc_i),
      .pop_i      (lsu_pop),
      .addr_i     (lsu_waddr_i),
      .head_o     (lsu_head),
      .full_o     (lsu_full),
      .empty_o    (lsu_empty),
      .cmp_a_i    (raddr_a_i),
      .cmp_b_i    (raddr_b_i),
      .cmp_ex_i   (ex_waddr_i),
      .match_a_o  (match_a),
      .match_b_o  (match_b),
      .match_ex_o (match_ex)
   );

   // No pop-through: a full scoreboard refuses allocation even on a pop.
   assign lsu_alloc_rdy_o = !lsu_full;
   assign lsu_pop         = lsu_rvalid_i && !lsu_empty;
   assign ex_ready_o      = !lsu_rvalid_i && !match_ex;
   assign ex_fire         = ex_valid_i && ex_ready_o;
   assign wb_src          = lsu_rvalid_i ? WB_SRC_LSU : WB_SRC_EX;

   always_comb begin
      wb_acc  = 1'b0;
      wb_drop = 1'b0;
      wb_addr = ex_waddr_i;
      wb_data = ex_wdata_i;
      unique case (wb_src)
         WB_SRC_LSU: begin
            wb_acc  = lsu_pop;
            wb_drop = lsu_err_i;
            wb_addr = lsu_head;
            wb_data = lsu_rdata_i;
         end
         WB_SRC_EX: begin
            wb_acc = ex_fire;
         end
         default: ;
      endcase
   end

   // x0 writes still retire the transaction but never strobe the RF.
   assign wb_we = wb_acc && !wb_drop && rf_addr_nz(wb_addr, RV32E);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rf_we_o     <= 1'b0;
         rf_waddr_o  <= '0;
         rf_wdata_o  <= '0;
         proto_err_o <= 1'b0;
      end else begin
         rf_we_o <= wb_we;
         if (wb_acc) begin
            rf_waddr_o <= rf_addr_mask(wb_addr, RV32E);
            rf_wdata_o <= wb_data;
         end
         if (lsu_rvalid_i && lsu_empty) proto_err_o <= 1'b1;
      end
   end

   assign os_a = rf_we_o && rf_addr_eq(rf_waddr_o, raddr_a_i, RV32E);
   assign os_b = rf_we_o && rf_addr_eq(rf_waddr_o, raddr_b_i, RV32E);

`ifdef IBEX_RF_WB_FWD_EN
   // Output-stage value is bypassed, so only pending loads stall ID.
   assign hazard_a_o = match_a;
   assign hazard_b_o = match_b;
   assign fwd_a_o    = os_a;
   assign fwd_b_o    = os_b;
   assign fwd_data_o = rf_wdata_o;
`else
   assign hazard_a_o = rf_addr_nz(raddr_a_i, RV32E) && (match_a || os_a);
   assign hazard_b_o = rf_addr_nz(raddr_b_i, RV32E) && (match_b || os_b);
`endif

endmodule

// File: tb/tb_ibex_rf_write_sequencer.sv
// Directed vector table plus randomized run against a queue-based model
// for ibex_rf_write_sequencer (default build, LsuDepth=2).
module tb_ibex_rf_write_sequencer;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        exv;
   logic        ex_rdy;
   logic [4:0]  exa;
   logic [31:0] exd;
   logic        al;
   logic        ardy;
   logic [4:0]  la;
   logic        rv;
   logic [31:0] rd;
   logic        er;
   logic [4:0]  ra;
   logic [4:0]  rb;
   logic        ha;
   logic        hb;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic        we;
   logic        perr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ibex_rf_write_sequencer #(
      .RV32E     (1'b0),
      .DataWidth (32),
      .LsuDepth  (DEPTH)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .ex_valid_i      (exv),
      .ex_ready_o      (ex_rdy),
      .ex_waddr_i      (exa),
      .ex_wdata_i      (exd),
      .lsu_alloc_i     (al),
      .lsu_alloc_rdy_o (ardy),
      .lsu_waddr_i     (la),
      .lsu_rvalid_i    (rv),
      .lsu_rdata_i     (rd),
      .lsu_err_i       (er),
      .raddr_a_i       (ra),
      .raddr_b_i       (rb),
      .hazard_a_o      (ha),
      .hazard_b_o      (hb),
      .rf_waddr_o      (wa),
      .rf_wdata_o      (wd),
      .rf_we_o         (we),
      .proto_err_o     (perr)
   );

   typedef struct {
      logic        rst, exv;
      logic [4:0]  exa;
      logic [31:0] exd;
      logic        al;
      logic [4:0]  la;
      logic        rv;
      logic [31:0] rd;
      logic        er;
      logic [4:0]  ra, rb;
      logic        e_rdy, e_ardy, e_ha, e_hb, e_we;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
      logic        e_perr;
   } vec_t;

   vec_t tbl[25];

   function automatic vec_t mk(
      input logic r, input logic v, input logic [4:0] a,
      input logic [31:0] d, input logic l, input logic [4:0] lw,
      input logic q, input logic [31:0] qd, input logic e,
      input logic [4:0] xa, input logic [4:0] xb,
      input logic c_rdy, input logic c_ardy, input logic c_ha,
      input logic c_hb, input logic c_we, input logic [4:0] c_wa,
      input logic [31:0] c_wd, input logic c_perr
   );
      vec_t t;
      t.rst = r; t.exv = v; t.exa = a; t.exd = d;
      t.al = l; t.la = lw; t.rv = q; t.rd = qd; t.er = e;
      t.ra = xa; t.rb = xb;
      t.e_rdy = c_rdy; t.e_ardy = c_ardy; t.e_ha = c_ha; t.e_hb = c_hb;
      t.e_we = c_we; t.e_wa = c_wa; t.e_wd = c_wd; t.e_perr = c_perr;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      rst = t.rst; exv = t.exv; exa = t.exa; exd = t.exd;
      al = t.al; la = t.la; rv = t.rv; rd = t.rd; er = t.er;
      ra = t.ra; rb = t.rb;
   endtask

   // Behavioural model: pending loads as a queue of addresses.
   logic [4:0]  mq[$];
   logic        m_we, m_perr;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;

   function automatic logic in_q(input logic [4:0] a);
      if (a == 0) return 1'b0;
      foreach (mq[i]) if (mq[i] == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic m_haz(input logic [4:0] a);
      return a != 0 && (in_q(a) || (m_we && m_wa == a));
   endfunction

   task automatic m_reset();
      mq.delete();
      m_we = 0; m_wa = 0; m_wd = 0; m_perr = 0;
   endtask

   task automatic m_step(input vec_t t, input logic rdy_ok,
                         input logic alloc_ok);
      logic [4:0] h;
      logic       nwe;
      if (t.rst) begin
         m_reset();
         return;
      end
      nwe = 0;
      if (t.rv) begin
         if (mq.size() > 0) begin
            h = mq.pop_front();
            nwe = !t.er && h != 0;
            m_wa = h; m_wd = t.rd;
         end else m_perr = 1;
      end else if (t.exv && rdy_ok) begin
         nwe = t.exa != 0;
         m_wa = t.exa; m_wd = t.exd;
      end
      if (t.al && alloc_ok) mq.push_back(t.la);
      m_we = nwe;
   endtask

   initial begin
      vec_t t;
      logic e_rdy, e_ardy;

      tbl[0]  = mk(0,1,5,32'hDEADBEEF,0,0,0,0,0,5,0, 1,1,0,0, 1,5,32'hDEADBEEF,0);
      tbl[1]  = mk(0,0,0,0,0,0,0,0,0,5,0, 1,1,1,0, 0,0,0,0);
      tbl[2]  = mk(0,0,0,0,1,7,0,0,0,7,0, 1,1,0,0, 0,0,0,0);
      tbl[3]  = mk(0,0,0,0,0,0,0,0,0,7,0, 1,1,1,0, 0,0,0,0);
      tbl[4]  = mk(0,0,0,0,0,0,1,32'h1234,0,7,0, 0,1,1,0, 1,7,32'h1234,0);
      tbl[5]  = mk(0,0,0,0,0,0,0,0,0,7,0, 1,1,1,0, 0,0,0,0);
      tbl[6]  = mk(0,0,0,0,0,0,0,0,0,7,0, 1,1,0,0, 0,0,0,0);
      tbl[7]  = mk(0,0,0,0,1,3,0,0,0,0,0, 1,1,0,0, 0,0,0,0);
      tbl[8]  = mk(0,1,3,32'hAA,0,0,0,0,0,0,3, 0,1,0,1, 0,0,0,0);
      tbl[9]  = mk(0,1,3,32'hAA,0,0,1,32'h55,0,0,3, 0,1,0,1, 1,3,32'h55,0);
      tbl[10] = mk(0,1,3,32'hAA,0,0,0,0,0,0,3, 1,1,0,1, 1,3,32'hAA,0);
      tbl[11] = mk(0,0,0,0,1,9,0,0,0,0,0, 1,1,0,0, 0,0,0,0);
      tbl[12] = mk(0,0,0,0,1,10,0,0,0,0,0, 1,1,0,0, 0,0,0,0);
      tbl[13] = mk(0,0,0,0,1,11,0,0,0,9,10, 1,0,1,1, 0,0,0,0);
      tbl[14] = mk(0,0,0,0,0,0,1,32'h77,1,9,0, 0,0,1,0, 0,0,0,0);
      tbl[15] = mk(0,0,0,0,1,12,1,32'h100,0,10,12, 0,1,1,0, 1,10,32'h100,0);
      tbl[16] = mk(0,0,0,0,0,0,1,32'h200,0,0,12, 0,1,0,1, 1,12,32'h200,0);
      tbl[17] = mk(0,0,0,0,0,0,1,32'h300,0,0,0, 0,1,0,0, 0,0,0,1);
      tbl[18] = mk(0,1,0,32'hFFFF,0,0,0,0,0,0,0, 1,1,0,0, 0,0,0,1);
      tbl[19] = mk(0,0,0,0,0,0,0,0,0,0,0, 1,1,0,0, 0,0,0,1);
      tbl[20] = mk(0,0,0,0,1,4,0,0,0,0,0, 1,1,0,0, 0,0,0,1);
      tbl[21] = mk(0,0,0,0,1,6,0,0,0,0,0, 1,1,0,0, 0,0,0,1);
      tbl[22] = mk(1,0,0,0,0,0,0,0,0,4,6, 1,0,1,1, 0,0,0,0);
      tbl[23] = mk(0,0,0,0,0,0,0,0,0,4,6, 1,1,0,0, 0,0,0,0);
      tbl[24] = mk(0,0,0,0,0,0,1,32'h1,0,0,0, 0,1,0,0, 0,0,0,1);

      t = mk(1,0,0,0,0,0,0,0,0,5,7, 0,0,0,0, 0,0,0,0);
      drive(t);
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      chk("rst_we", we, 0);
      chk("rst_waddr", wa, 0);
      chk("rst_wdata", wd, 0);
      chk("rst_perr", perr, 0);
      chk("rst_ex_rdy", ex_rdy, 1);
      chk("rst_ardy", ardy, 1);
      chk("rst_ha", ha, 0);
      chk("rst_hb", hb, 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 25; i++) begin
         drive(tbl[i]);
         @(negedge clk);
         chk($sformatf("v%0d_ex_rdy", i), ex_rdy, tbl[i].e_rdy);
         chk($sformatf("v%0d_ardy", i), ardy, tbl[i].e_ardy);
         chk($sformatf("v%0d_ha", i), ha, tbl[i].e_ha);
         chk($sformatf("v%0d_hb", i), hb, tbl[i].e_hb);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_we", i), we, tbl[i].e_we);
         chk($sformatf("v%0d_perr", i), perr, tbl[i].e_perr);
         if (tbl[i].e_we || tbl[i].rst) begin
            chk($sformatf("v%0d_waddr", i), wa, tbl[i].e_wa);
            chk($sformatf("v%0d_wdata", i), wd, tbl[i].e_wd);
         end
      end

      t = mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0);
      drive(t);
      @(posedge clk);
      #1;
      m_reset();

      for (int n = 0; n < 600; n++) begin
         t.rst = ($urandom_range(0, 99) == 0);
         t.exv = $urandom_range(0, 1);
         t.exa = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) t.exa = t.exa | 5'd16;
         t.exd = $urandom;
         t.al  = ($urandom_range(0, 9) < 4);
         t.la  = 5'($urandom_range(0, 7));
         if (mq.size() == 0) t.rv = ($urandom_range(0, 19) == 0);
         else t.rv = ($urandom_range(0, 9) < 4);
         t.rd  = $urandom;
         t.er  = ($urandom_range(0, 7) == 0);
         t.ra  = 5'($urandom_range(0, 7));
         t.rb  = 5'($urandom_range(0, 7));
         drive(t);
         e_rdy  = !t.rv && !in_q(t.exa);
         e_ardy = mq.size() < DEPTH;
         @(negedge clk);
         chk($sformatf("r%0d_ex_rdy", n), ex_rdy, e_rdy);
         chk($sformatf("r%0d_ardy", n), ardy, e_ardy);
         chk($sformatf("r%0d_ha", n), ha, m_haz(t.ra));
         chk($sformatf("r%0d_hb", n), hb, m_haz(t.rb));
         m_step(t, e_rdy, e_ardy);
         @(posedge clk);
         #1;
         chk($sformatf("r%0d_we", n), we, m_we);
         chk($sformatf("r%0d_perr", n), perr, m_perr);
         if (m_we) begin
            chk($sformatf("r%0d_waddr", n), wa, m_wa);
            chk($sformatf("r%0d_wdata", n), wd, m_wd);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
